// File: rtl/plru_pkg.sv
// Shared types and helpers for the tree pseudo-LRU state block.
// The helpers work on maximum-size vectors so that any legal WIDTH up to MAX_WIDTH can reuse them.
package plru_pkg;

  localparam int PLRU_WIDTH = 4;
  localparam int LVL        = $clog2(PLRU_WIDTH);
  localparam int NODES      = PLRU_WIDTH - 1;

  localparam int MAX_WIDTH  = 64;
  localparam int MAX_NODES  = MAX_WIDTH - 1;
  localparam int MAX_LVL    = $clog2(MAX_WIDTH);

  typedef enum logic {IDLE, HOLD} fsm_e;

  function automatic logic onehot_ok(input logic [MAX_WIDTH-1:0] vec);
    return $onehot(vec);
  endfunction

  // Walk root to leaf pair; each visited node is set to point away from idx
  // (0 when idx is in the left subtree, 1 when it is in the right subtree).
  function automatic logic [MAX_NODES-1:0] path_update(input logic [MAX_NODES-1:0] state,
                                                       input int idx,
                                                       input int lvl);
    logic [MAX_NODES-1:0] nxt;
    int                   node;
    logic                 b;
    nxt  = state;
    node = 0;
    for (int l = 0; l < MAX_LVL; l++) begin
      if (l < lvl) begin
        b = ((idx >> (lvl - 1 - l)) & 1) != 0;
        nxt[node[MAX_LVL-1:0]] = b;
        node = 2 * node + 1 + int'(b);
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/plru_onehot_enc.sv
// One-hot to binary index encoder with a legality flag; purely combinational.
module plru_onehot_enc
  import plru_pkg::*;
#(
  parameter int WIDTH = PLRU_WIDTH,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             legal
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
    legal = onehot_ok(MAX_WIDTH'(onehot));
  end

endmodule

// File: rtl/plru_state.sv
// Tree pseudo-LRU state register for a WIDTH-way arbiter, with burst-lock deferral
// and detection of malformed grant vectors.
module plru_state
  import plru_pkg::*;
#(
  parameter int WIDTH = PLRU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             gnt_vld,
  input  logic [WIDTH-1:0] gnt_onehot,
  input  logic             gnt_lock,
  output logic [WIDTH-2:0] v_grant,
  output logic             locked,
  output logic             gnt_err
);

  localparam int W_LVL   = $clog2(WIDTH);
  localparam int W_NODES = WIDTH - 1;

  fsm_e               state_q, state_d;
  logic [W_LVL-1:0]   pend_q, pend_d;
  logic [W_NODES-1:0] v_grant_q, v_grant_d;
  logic               gnt_err_q, gnt_err_d;
  logic [W_LVL-1:0]   enc_idx;
  logic [W_LVL-1:0]   sel_idx;
  logic               enc_legal;
  logic               grant_ok;

  plru_onehot_enc #(.WIDTH(WIDTH)) u_enc (
    .onehot (gnt_onehot),
    .idx    (enc_idx),
    .legal  (enc_legal)
  );

  assign grant_ok = gnt_vld && enc_legal;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    v_grant_d = v_grant_q;
    gnt_err_d = 1'b0;
    sel_idx   = enc_idx;
    if (clr) begin
      state_d   = IDLE;
      pend_d    = '0;
      v_grant_d = '1;
    end else begin
      gnt_err_d = gnt_vld && !enc_legal;
      case (state_q)
        IDLE: begin
          if (grant_ok) begin
            if (gnt_lock) begin
              pend_d  = enc_idx;
              state_d = HOLD;
            end else begin
              v_grant_d = W_NODES'(path_update(MAX_NODES'(v_grant_q), int'(enc_idx), W_LVL));
            end
          end
        end
        HOLD: begin
          // A fresh legal grant in the release cycle wins over the stored one.
          sel_idx = grant_ok ? enc_idx : pend_q;
          pend_d  = sel_idx;
          if (!gnt_lock) begin
            v_grant_d = W_NODES'(path_update(MAX_NODES'(v_grant_q), int'(sel_idx), W_LVL));
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      v_grant_q <= '1;
      gnt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      v_grant_q <= v_grant_d;
      gnt_err_q <= gnt_err_d;
    end
  end

  assign v_grant = v_grant_q;
  assign locked  = (state_q == HOLD);
  assign gnt_err = gnt_err_q;

endmodule

// File: tb/tb_plru_state.sv
// Self-checking bench for plru_state (WIDTH=4): directed scenarios followed by
// randomized traffic compared against a level-by-level reference model.
module tb_plru_state;

  localparam int W  = 4;
  localparam int LV = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         gnt_vld = 1'b0;
  logic [W-1:0] gnt_onehot = '0;
  logic         gnt_lock = 1'b0;
  logic [W-2:0] v_grant;
  logic         locked;
  logic         gnt_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-2:0] m_v = '1;
  logic         m_hold = 1'b0;
  int           m_pend = 0;
  logic         m_err = 1'b0;

  plru_state #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .gnt_vld    (gnt_vld),
    .gnt_onehot (gnt_onehot),
    .gnt_lock   (gnt_lock),
    .v_grant    (v_grant),
    .locked     (locked),
    .gnt_err    (gnt_err)
  );

  always #5 clk = ~clk;

  // Level l of the tree holds 2^l nodes starting at 2^l-1; requester r sits under
  // node (r >> (LV-l)) of that level and goes right when its bit (LV-1-l) is set.
  function automatic logic [W-2:0] model_update(input logic [W-2:0] v, input int r);
    logic [W-2:0] res;
    int           node;
    res = v;
    for (int l = 0; l < LV; l++) begin
      node = (1 << l) - 1 + (r >> (LV - l));
      res[node] = ((r >> (LV - 1 - l)) & 1) != 0;
    end
    return res;
  endfunction

  function automatic int first_set(input logic [W-1:0] vec);
    for (int i = 0; i < W; i++) if (vec[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_v    = '1;
    m_hold = 1'b0;
    m_pend = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_step(input logic vld, input logic [W-1:0] oh, input logic lck, input logic c);
    logic legal;
    int   r;
    legal = ($countones(oh) == 1);
    r     = first_set(oh);
    if (c) begin
      model_reset();
    end else begin
      m_err = vld && !legal;
      if (m_hold) begin
        if (vld && legal) m_pend = r;
        if (!lck) begin
          m_v    = model_update(m_v, m_pend);
          m_hold = 1'b0;
        end
      end else if (vld && legal) begin
        if (lck) begin
          m_pend = r;
          m_hold = 1'b1;
        end else begin
          m_v = model_update(m_v, r);
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    tests_run++;
    assert (v_grant === m_v) else begin
      tests_failed++;
      $error("[TB] FAIL %s v_grant: got %b expected %b", tag, v_grant, m_v);
    end
    tests_run++;
    assert (locked === m_hold) else begin
      tests_failed++;
      $error("[TB] FAIL %s locked: got %b expected %b", tag, locked, m_hold);
    end
    tests_run++;
    assert (gnt_err === m_err) else begin
      tests_failed++;
      $error("[TB] FAIL %s gnt_err: got %b expected %b", tag, gnt_err, m_err);
    end
  endtask

  // Called at a negedge: drive, let the DUT sample, update the model, check at the next negedge.
  task automatic applyStimulus(input logic vld, input logic [W-1:0] oh, input logic lck,
                               input logic c, input string tag);
    gnt_vld    = vld;
    gnt_onehot = oh;
    gnt_lock   = lck;
    clr        = c;
    @(posedge clk);
    model_step(vld, oh, lck, c);
    @(negedge clk);
    gnt_vld    = 1'b0;
    gnt_onehot = '0;
    gnt_lock   = 1'b0;
    clr        = 1'b0;
    checkOutput(tag);
  endtask

  task automatic expectV(input logic [W-2:0] want, input logic want_lock, input string tag);
    tests_run++;
    assert (v_grant === want && locked === want_lock) else begin
      tests_failed++;
      $error("[TB] FAIL %s: got v_grant=%b locked=%b expected v_grant=%b locked=%b",
             tag, v_grant, locked, want, want_lock);
    end
  endtask

  initial begin
    logic [W-1:0] oh;
    logic         vld, lck, c;

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    checkOutput("reset");

    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, "grant0");
    expectV(3'b100, 1'b0, "grant0_const");

    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, "clr1");
    applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0, "grant2");
    expectV(3'b011, 1'b0, "grant2_const");
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, "grant3");
    expectV(3'b111, 1'b0, "grant3_const");

    applyStimulus(1'b1, 4'b0001, 1'b1, 1'b0, "lock0");
    expectV(3'b111, 1'b1, "lock0_const");
    applyStimulus(1'b1, 4'b0100, 1'b1, 1'b0, "hold_grant2");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, "release");
    expectV(3'b011, 1'b0, "release_const");

    applyStimulus(1'b1, 4'b0110, 1'b0, 1'b0, "multihot");
    tests_run++;
    assert (gnt_err === 1'b1) else begin
      tests_failed++;
      $error("[TB] FAIL multihot_err: got %b expected 1", gnt_err);
    end
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, "err_clear");
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, "zerohot");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, "err_clear2");

    applyStimulus(1'b1, 4'b0010, 1'b1, 1'b0, "lock1");
    applyStimulus(1'b1, 4'b0100, 1'b0, 1'b1, "clr_in_hold");
    expectV(3'b111, 1'b0, "clr_in_hold_const");
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, "after_clr");

    applyStimulus(1'b1, 4'b1000, 1'b1, 1'b0, "lock3");
    rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, "post_reset");
    expectV(3'b111, 1'b0, "post_reset_const");

    for (int i = 0; i < 400; i++) begin
      vld = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 8) oh = 4'(1 << $urandom_range(0, W - 1));
      else oh = 4'($urandom_range(0, 15));
      lck = ($urandom_range(0, 2) == 0);
      c   = ($urandom_range(0, 39) == 0);
      applyStimulus(vld, oh, lck, c, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/plru_state.md
# plru_state

Holds and updates the tree pseudo-LRU state vector `v_grant` (WIDTH-1 node bits) for a WIDTH-way arbiter. It samples the one-hot grant issued each cycle and re-points every tree node on the granted requester's path away from it. The registered `v_grant` feeds `plru_mapping` directly, which expands it into the priority matrix. A lock input defers updates across multi-cycle (burst) grants.

## Interface
- `WIDTH`, default 4: number of requesters; power of two, ≥2.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `clr` in 1: synchronous clear to reset state; highest priority.
- `gnt_vld` in 1: `gnt_onehot` is valid this cycle.
- `gnt_onehot` in WIDTH: granted requester, one-hot.
- `gnt_lock` in 1: current grant is a burst; defer the tree update.
- `v_grant` out WIDTH-1: registered PLRU tree state, heap order, connected to `plru_mapping`.
- `locked` out 1: the FSM is in HOLD.
- `gnt_err` out 1: one-cycle pulse; previous cycle's `gnt_vld` carried a zero or multi-hot vector.

## Operation
- Tree layout is heap order:
  - Node 0 is the root.
  - The children of node n are 2n+1 and 2n+2.
  - Leaf-pair nodes are WIDTH/2-1 … WIDTH-2.
  - Node bit = 1 means the left (lower-index) subtree has priority over the right.
- Update for granted index r: each node on the path from root to r's leaf pair is written. It is set to 0 if r lies in that node's left subtree, and to 1 if r lies in the right subtree. Nodes off the path are unchanged.
- Grant check:
  - A grant is legal only when `gnt_onehot` has exactly one bit set.
  - An illegal grant with `gnt_vld` is dropped: no state change, no pending capture, and `gnt_err` is 1 on the next cycle.
- FSM states are IDLE and HOLD.
- IDLE:
  - Legal `gnt_vld` with `gnt_lock`=0: apply the update; stay in IDLE.
  - Legal `gnt_vld` with `gnt_lock`=1: store r in the pending register; go to HOLD; `v_grant` is unchanged.
- HOLD:
  - A legal `gnt_vld` overwrites the pending index (last wins).
  - When `gnt_lock`=0 is sampled, apply the update for the pending index and go to IDLE. If a legal `gnt_vld` arrives in that same cycle, its index is the one applied.
  - An illegal grant in HOLD is dropped and the pending index is kept.
- `clr`:
  - Sets `v_grant` to all ones, the FSM to IDLE, the pending index to 0 and `gnt_err` to 0.
  - It overrides any grant or lock event in the same cycle.

## Timing
- Reset values: `v_grant`=all ones (requester 0 highest priority), `locked`=0, `gnt_err`=0, FSM=IDLE, pending=0.
- Latency:
  - A grant sampled at edge t appears in `v_grant` after edge t, i.e. usable by the mapping and arbiter in cycle t+1.
  - A deferred update appears one cycle after `gnt_lock`=0 is sampled.
- `locked` rises the cycle after a legal locked grant and falls the cycle after release.
- Back-to-back grants every cycle are supported with no bubbles; each one updates against the state produced by the previous one.
- Asserting `rst_n` low mid-burst discards the pending index immediately; no update occurs after reset is released.
- `gnt_lock` is ignored when `gnt_vld`=0 in IDLE.

## Structure
- Package `plru_pkg` holds:
  - localparams `LVL = $clog2(WIDTH)` and `NODES = WIDTH-1`.
  - typedef `fsm_e {IDLE, HOLD}`.
  - function `onehot_ok(vec)`.
  - function `path_update(state, idx)`, which returns the next tree state.
- Sub-module `plru_onehot_enc`: one-hot → binary index plus a legality flag, purely combinational.
- The top level holds the FSM, the pending register, the `v_grant` register and the `gnt_err` flop.

## Test plan
All scenarios use WIDTH=4; `v_grant` is written bit2..bit0.
- Reset, then grant 4'b0001 → `v_grant` goes from 3'b111 to 3'b100 one cycle later.
- From reset, grants 4'b0100 then 4'b1000 on consecutive cycles → 3'b011, then 3'b111.
- Grant 4'b0001 with `gnt_lock`=1 → `locked`=1 and `v_grant` holds at 3'b111. A later grant 4'b0100 during HOLD, then release → `v_grant`=3'b011 and `locked`=0.
- Grant 4'b0110 with `gnt_vld` → `gnt_err` pulses high one cycle and `v_grant` is unchanged. The same check with 4'b0000.
- `clr` and a legal grant in the same cycle while in HOLD → `v_grant`=3'b111, `locked`=0, no update.
- `rst_n` asserted low in HOLD, then released → all outputs at reset values; no deferred update ever appears.
